// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory.
//   master : the control FSM (drives all control outputs, reads IR fields,
//            ALU zero flag and memory ready)
//   slave  : the datapath / memory side
// Memory handshake: mem_req is raised by the master and held (with mem_we and
// iord stable) until the cycle in which the slave returns mem_ready=1; that
// cycle completes the access. mem_ready is ignored while mem_req=0.
interface mc_ctrl_fsm_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [2:0]  reg_dst_sel;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        illegal;
  logic        bus_err;
  logic [31:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst_sel, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           illegal, bus_err, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           reg_dst_sel, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           illegal, bus_err, retired
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the MIPS-subset CPU: fetch, decode, execute,
// memory and writeback sequencing, with a retired-instruction counter, an
// illegal-instruction trap and a memory-timeout trap.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        mc_ctrl_fsm_if.master: IR fields, zero flag, memory handshake
//              and all datapath selects / status outputs
//   state_dbg  current state encoding (see state_t) for observation
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_fsm_if.master bus,
  output logic [3:0]    state_dbg
);

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REX     = 4'd7,
    S_RWB     = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_JR      = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;

  // Wait counter only needs to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the cycle that traps.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   retired;
  logic          illegal;
  logic          bus_err;

  // Decode helpers
  logic          r_alu_ok;
  logic [2:0]    r_alu_op;
  state_t        dispatch;
  logic          mem_state;

  always_comb begin
    r_alu_ok = 1'b1;
    r_alu_op = ALU_ADD;
    case (bus.funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: r_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    dispatch = S_HALT;
    case (bus.opcode)
      OP_LW, OP_SW:   dispatch = S_MEMADDR;
      OP_RTYPE: begin
        if (bus.funct == FN_JR) dispatch = S_JR;
        else if (r_alu_ok)      dispatch = S_REX;
        else                    dispatch = S_HALT;
      end
      OP_ADDI, OP_ORI: dispatch = S_IEX;
      OP_BEQ:          dispatch = S_BRANCH;
      OP_J:            dispatch = S_JUMP;
      OP_JAL:          dispatch = S_JAL;
      default:         dispatch = S_HALT;
    endcase
  end

  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else if (mem_state && !bus.mem_ready) begin
      // Stalled memory access: count, and trap once the limit is hit.
      if (wait_cnt == WAIT_LAST) begin
        state    <= S_HALT;
        bus_err  <= 1'b1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      case (state)
        S_INIT:    state <= S_FETCH;
        S_FETCH:   state <= S_DECODE;
        S_DECODE: begin
          state <= dispatch;
          if (dispatch == S_HALT) illegal <= 1'b1;
        end
        S_MEMADDR: state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   state <= S_MEMWB;
        S_REX:     state <= S_RWB;
        S_IEX:     state <= S_IWB;
        S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
          state   <= S_FETCH;
          retired <= retired + 32'd1;
        end
        default:   state <= S_HALT;
      endcase
    end
  end

  // Moore decode of the state register. ir_write/pc_write in FETCH are
  // qualified by mem_ready so the IR and PC load only on the completing
  // cycle; pc_write in BRANCH follows the zero flag.
  logic       o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write;
  logic [1:0] o_pc_src;
  logic       o_reg_write;
  logic [2:0] o_reg_dst_sel;
  logic       o_mem_to_reg, o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [2:0] o_alu_op;

  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_iord        = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_pc_src      = 2'b00;
    o_reg_write   = 1'b0;
    o_reg_dst_sel = 3'b000;
    o_mem_to_reg  = 1'b0;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'b00;
    o_alu_op      = ALU_ADD;
    case (state)
      S_FETCH: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = 2'b01;
        o_ir_write  = bus.mem_ready;
        o_pc_write  = bus.mem_ready;
      end
      S_DECODE:  o_alu_src_b = 2'b10;
      S_MEMADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write   = 1'b1;
        o_reg_dst_sel = 3'b001;
        o_mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_iord    = 1'b1;
      end
      S_REX: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = r_alu_op;
      end
      S_RWB: begin
        o_reg_write   = 1'b1;
        o_reg_dst_sel = 3'b010;
      end
      S_IEX: begin
        o_alu_src_a = 1'b1;
        if (bus.opcode == OP_ORI) begin
          o_alu_src_b = 2'b11;
          o_alu_op    = ALU_OR;
        end else begin
          o_alu_src_b = 2'b10;
        end
      end
      S_IWB: begin
        o_reg_write   = 1'b1;
        o_reg_dst_sel = 3'b001;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_SUB;
        o_pc_write  = bus.zero;
        o_pc_src    = 2'b01;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = 2'b10;
      end
      S_JAL: begin
        o_pc_write    = 1'b1;
        o_pc_src      = 2'b10;
        o_reg_write   = 1'b1;
        o_reg_dst_sel = 3'b100;
      end
      S_JR: begin
        o_pc_write = 1'b1;
        o_pc_src   = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.mem_req     = o_mem_req;
  assign bus.mem_we      = o_mem_we;
  assign bus.iord        = o_iord;
  assign bus.ir_write    = o_ir_write;
  assign bus.pc_write    = o_pc_write;
  assign bus.pc_src      = o_pc_src;
  assign bus.reg_write   = o_reg_write;
  assign bus.reg_dst_sel = o_reg_dst_sel;
  assign bus.mem_to_reg  = o_mem_to_reg;
  assign bus.alu_src_a   = o_alu_src_a;
  assign bus.alu_src_b   = o_alu_src_b;
  assign bus.alu_op      = o_alu_op;
  assign bus.illegal     = illegal;
  assign bus.bus_err     = bus_err;
  assign bus.retired     = retired;
  assign state_dbg       = state;

endmodule
